sar_sequencer: RTL and testbench
================================

# sar_sequencer

Successive-approximation sequencer for the discrete SAR ADC. It drives the PWM DAC with trial codes and waits for the DAC's settled-ready rising edge on each trial. It then samples the external comparator and resolves one bit per trial, MSB first. It sits between the PWM DAC/settle logic and the result consumer, and owns the edge detection on the DAC ready line.

## Interface
- `N_BITS`, 8: conversion width.
- `SETTLE_CYCLES`, 4: extra cycles waited after the ready edge before sampling the comparator; 0 is legal.
- `TIMEOUT_CYCLES`, 65535: maximum cycles spent waiting for a ready edge before the conversion aborts.
- `clk` in 1: system clock; the only clock.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: level; sampled only in IDLE.
- `abort` in 1: synchronous cancel of a conversion in progress.
- `dac_ready` in 1: PWM DAC settled level, already synchronous to `clk`.
- `comp_in` in 1: comparator output, already synchronous; 1 means Vin >= Vdac.
- `dac_code` out N_BITS: current trial code.
- `dac_load` out 1: one-cycle strobe telling the DAC to take `dac_code`.
- `busy` out 1: high from the cycle after `start` is accepted until the sequencer returns to IDLE.
- `result` out N_BITS: last completed conversion; held until the next completion.
- `done` out 1: one-cycle pulse when `result` updates.
- `timeout_err` out 1: one-cycle pulse on timeout.

## Operation
- States: IDLE, LOAD, WAIT_RDY, SETTLE, COMPARE, FINISH.
- IDLE:
  - If `start`=1: bit index i=N_BITS-1, `dac_code`={1,0...0}, go to LOAD.
  - `start` asserted in any other state is ignored.
- LOAD: `dac_load`=1 for exactly this cycle; clear the wait counter; go to WAIT_RDY.
- WAIT_RDY:
  - Advance only on a rising edge of `dac_ready`: edge = `dac_ready` & ~`dac_ready_q`. A level that is already high does not count.
  - An edge that occurs while in LOAD is discarded.
  - On an edge, clear the settle counter and go to SETTLE, or to COMPARE if SETTLE_CYCLES=0.
  - Each cycle without an edge increments the wait counter. On reaching TIMEOUT_CYCLES: pulse `timeout_err`, go to IDLE; `result` is unchanged and `done` does not pulse.
- SETTLE: count SETTLE_CYCLES cycles, then go to COMPARE.
- COMPARE:
  - Sample `comp_in`. If 0, clear bit i of `dac_code`; if 1, keep it.
  - If i=0, go to FINISH.
  - Otherwise i<=i-1, set bit i-1 of `dac_code`, go to LOAD.
- FINISH: `result`<=`dac_code`, `done`=1 for one cycle, go to IDLE.
- `abort`=1 in any non-IDLE state: go to IDLE next cycle. No `done`, no `timeout_err`; `result` is unchanged. `abort` has priority over every other transition in the same cycle.
- `dac_code` holds its last value in IDLE.

## Timing
- Reset values: state IDLE; `dac_code`, `result`, and the `dac_ready_q` register all 0; `dac_load`, `busy`, `done`, `timeout_err` all 0.
- Reset takes effect immediately, including mid-conversion. The first conversion after reset needs a new `start`.
- Per-bit latency = 1 (LOAD) + W + SETTLE_CYCLES + 1 (COMPARE), where W is the number of cycles from LOAD exit to the detected edge (minimum 1).
- Total latency from `start` sampled to `done` = 1 + N_BITS*(per-bit) + 1.
- `done` and `busy` deassertion occur in the same cycle as the transition to IDLE. `start` can be accepted on the following cycle.
- All outputs are registered except `busy`, which is decoded from state.

## Structure
- Package `sar_pkg`: state enum `sar_state_t`, and default width constants for N_BITS, SETTLE_CYCLES and TIMEOUT_CYCLES.
- Counter widths are $clog2 of each parameter, with a minimum of 1 bit.
- One sub-module, `sar_edge_det`: a rising-edge detector with asynchronous active-low reset and the `dac_ready_q` register reset to 0.
- Wait counter, settle counter and bit index live in `sar_sequencer`.

## Test plan
- Comparator model Vin=0xA5, DAC raises `dac_ready` 3 cycles after each `dac_load`:
  - `dac_code` sequence must be 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5.
  - `result`=0xA5 with a single `done` pulse.
  - Total latency matches the formula.
- Extremes: Vin=0x00 gives `result`=0x00; Vin=0xFF gives `result`=0xFF. `start` held high through both gives back-to-back conversions with one IDLE cycle between them.
- `dac_ready` held high constantly, TIMEOUT_CYCLES=16:
  - No bit resolves.
  - `timeout_err` pulses 16 cycles into WAIT_RDY, then the sequencer returns to IDLE.
  - `result` keeps its previous value.
- `abort` asserted in trial 4 while an edge arrives in the same cycle: abort wins, IDLE next cycle, no `done`. A new `start` then yields a correct full conversion.
- `reset` asserted low mid-SETTLE, asynchronously between clock edges: all outputs 0 immediately. After release, nothing happens until `start`.
- `start` pulsed while busy, and a ready edge timed to land in the LOAD cycle: the extra `start` is ignored, the LOAD-cycle edge is discarded, and the sequencer waits for the next edge.

Source files
------------

// File: rtl/sar_pkg.sv
// rtl/sar_pkg.sv - shared state type, default widths and counter sizing for the SAR sequencer
package sar_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_WAIT_RDY = 3'd2,
    S_SETTLE   = 3'd3,
    S_COMPARE  = 3'd4,
    S_FINISH   = 3'd5
  } sar_state_t;

  localparam int SAR_N_BITS         = 8;
  localparam int SAR_SETTLE_CYCLES  = 4;
  localparam int SAR_TIMEOUT_CYCLES = 65535;

  // Counters never shrink below one bit, even for degenerate parameter values.
  function automatic int cnt_width(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/sar_edge_det.sv
// rtl/sar_edge_det.sv - rising-edge detector on the synchronous DAC ready level
module sar_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic i_level,
  output logic o_rise
);

  logic r_level_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_level_q <= 1'b0;
    end else begin
      r_level_q <= i_level;
    end
  end

  assign o_rise = i_level & ~r_level_q;

endmodule

// File: rtl/sar_sequencer.sv
// rtl/sar_sequencer.sv - successive-approximation sequencer driving the PWM DAC, MSB first
module sar_sequencer
  import sar_pkg::*;
#(
  parameter int N_BITS         = SAR_N_BITS,
  parameter int SETTLE_CYCLES  = SAR_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = SAR_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              dac_ready,
  input  logic              comp_in,
  output logic [N_BITS-1:0] dac_code,
  output logic              dac_load,
  output logic              busy,
  output logic [N_BITS-1:0] result,
  output logic              done,
  output logic              timeout_err
);

  localparam int BW = cnt_width(N_BITS);
  localparam int SW = cnt_width(SETTLE_CYCLES);
  localparam int WW = cnt_width(TIMEOUT_CYCLES);

  localparam logic [SW-1:0]     SETTLE_LAST = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [WW-1:0]     WAIT_LAST   = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [N_BITS-1:0] CODE_MSB    = {1'b1, {(N_BITS-1){1'b0}}};
  localparam logic [N_BITS-1:0] CODE_ONE    = N_BITS'(1);

  sar_state_t        r_state;
  logic [BW-1:0]     r_bit_idx;
  logic [SW-1:0]     r_settle_cnt;
  logic [WW-1:0]     r_wait_cnt;
  logic [N_BITS-1:0] r_dac_code;
  logic [N_BITS-1:0] r_result;
  logic              r_dac_load;
  logic              r_done;
  logic              r_timeout_err;

  logic              w_rdy_rise;
  logic [N_BITS-1:0] w_bit_mask;
  logic [N_BITS-1:0] w_code_resolved;

  sar_edge_det u_edge_det (
    .clk     (clk),
    .reset   (reset),
    .i_level (dac_ready),
    .o_rise  (w_rdy_rise)
  );

  // Trial bit survives only when the comparator says Vin >= Vdac.
  assign w_bit_mask      = CODE_ONE << r_bit_idx;
  assign w_code_resolved = comp_in ? r_dac_code : (r_dac_code & ~w_bit_mask);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_bit_idx     <= '0;
      r_settle_cnt  <= '0;
      r_wait_cnt    <= '0;
      r_dac_code    <= '0;
      r_result      <= '0;
      r_dac_load    <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_dac_load    <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
      if (abort && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_bit_idx  <= BW'(N_BITS - 1);
              r_dac_code <= CODE_MSB;
              r_dac_load <= 1'b1;
              r_state    <= S_LOAD;
            end
          end
          S_LOAD: begin
            r_wait_cnt <= '0;
            r_state    <= S_WAIT_RDY;
          end
          S_WAIT_RDY: begin
            if (w_rdy_rise) begin
              r_settle_cnt <= '0;
              r_state      <= (SETTLE_CYCLES == 0) ? S_COMPARE : S_SETTLE;
            end else if (r_wait_cnt == WAIT_LAST) begin
              r_timeout_err <= 1'b1;
              r_state       <= S_IDLE;
            end else begin
              r_wait_cnt <= r_wait_cnt + WW'(1);
            end
          end
          S_SETTLE: begin
            if (r_settle_cnt == SETTLE_LAST) begin
              r_state <= S_COMPARE;
            end else begin
              r_settle_cnt <= r_settle_cnt + SW'(1);
            end
          end
          S_COMPARE: begin
            if (r_bit_idx == '0) begin
              r_dac_code <= w_code_resolved;
              r_state    <= S_FINISH;
            end else begin
              r_dac_code <= w_code_resolved | (w_bit_mask >> 1);
              r_bit_idx  <= r_bit_idx - BW'(1);
              r_dac_load <= 1'b1;
              r_state    <= S_LOAD;
            end
          end
          S_FINISH: begin
            r_result <= r_dac_code;
            r_done   <= 1'b1;
            r_state  <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign dac_code    = r_dac_code;
  assign dac_load    = r_dac_load;
  assign busy        = (r_state != S_IDLE);
  assign result      = r_result;
  assign done        = r_done;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_sar_sequencer.sv
// tb/tb_sar_sequencer.sv - self-checking bench for sar_sequencer with a comparator/DAC model
module tb_sar_sequencer;

  localparam int NB  = 8;
  localparam int SET = 4;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic          dac_ready;
  logic          comp_in;
  logic [NB-1:0] dac_code;
  logic          dac_load;
  logic          busy;
  logic [NB-1:0] result;
  logic          done;
  logic          timeout_err;

  logic [NB-1:0] vin;
  logic [NB-1:0] load_q[$];
  int n_total   = 0;
  int n_pass    = 0;
  int cyc       = 0;
  int n_done    = 0;
  int n_to      = 0;
  int dac_mode  = 0;
  int rdy_delay = 3;
  int rdy_cd    = 0;

  always #5 clk = ~clk;

  assign comp_in = (vin >= dac_code);

  sar_sequencer #(
    .N_BITS         (NB),
    .SETTLE_CYCLES  (SET),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .dac_ready   (dac_ready),
    .comp_in     (comp_in),
    .dac_code    (dac_code),
    .dac_load    (dac_load),
    .busy        (busy),
    .result      (result),
    .done        (done),
    .timeout_err (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: mode 0 raises ready a fixed delay after each load, mode 1 holds it, mode 2 is manual.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (dac_load) begin
      load_q.push_back(dac_code);
      if (dac_mode == 0) begin
        dac_ready = 1'b0;
        rdy_cd    = rdy_delay;
      end
    end else if (dac_mode == 0 && rdy_cd > 0) begin
      rdy_cd--;
      if (rdy_cd == 0) dac_ready = 1'b1;
    end
    if (done) n_done++;
    if (timeout_err) n_to++;
  endtask

  task automatic run_conv(input logic [NB-1:0] v, input int d, input string tag);
    logic [NB-1:0] code;
    logic [NB-1:0] trial;
    logic [NB-1:0] one;
    vin = v; rdy_delay = d; dac_mode = 0;
    load_q.delete(); n_done = 0; n_to = 0;
    start = 1'b1; cyc = 0;
    step();
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    while (n_done == 0 && n_to == 0 && cyc < 400) step();
    check({tag, "_latency"}, cyc, 2 + NB * (d + SET + 2));
    check({tag, "_result"}, result, v);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_nloads"}, load_q.size(), NB);
    code = '0;
    one  = 1;
    for (int b = NB - 1; b >= 0; b--) begin
      trial = code | (one << b);
      if (load_q.size() > NB - 1 - b)
        check($sformatf("%s_code%0d", tag, b), load_q[NB - 1 - b], trial);
      if (v >= trial) code = trial;
    end
    step();
    check({tag, "_done_once"}, n_done, 1);
    check({tag, "_done_low"}, done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; dac_ready = 1'b0; vin = '0;
    repeat (2) @(negedge clk);
    check("rst_code", dac_code, 0);
    check("rst_result", result, 0);
    check("rst_busy", busy, 0);
    check("rst_load", dac_load, 0);
    check("rst_done", done, 0);
    check("rst_to", timeout_err, 0);
    reset = 1'b1;
    repeat (3) step();
    check("idle_busy", busy, 0);

    // Vin = 0xA5 with ready 3 cycles after each load.
    run_conv(8'hA5, 3, "a5");

    // Extremes back to back with start held high.
    vin = 8'h00; rdy_delay = 3; dac_mode = 0;
    load_q.delete(); n_done = 0; start = 1'b1; cyc = 0;
    while (n_done == 0 && cyc < 400) step();
    check("b2b0_latency", cyc, 2 + NB * (3 + SET + 2));
    check("b2b0_result", result, 8'h00);
    check("b2b0_busy", busy, 0);
    vin = 8'hFF; n_done = 0; cyc = 0; load_q.delete();
    step();
    check("b2b_restart_busy", busy, 1);
    check("b2b_restart_load", dac_load, 1);
    while (n_done == 0 && cyc < 400) step();
    start = 1'b0;
    check("b2b1_latency", cyc, 2 + NB * (3 + SET + 2));
    check("b2b1_result", result, 8'hFF);
    check("b2b1_nloads", load_q.size(), NB);
    step();
    check("b2b_stop_busy", busy, 0);

    // Ready held high: no edge ever, timeout after 16 waiting cycles.
    dac_mode = 1; dac_ready = 1'b1;
    load_q.delete(); n_done = 0; n_to = 0; start = 1'b1; cyc = 0;
    step();
    start = 1'b0;
    while (n_to == 0 && cyc < 100) step();
    check("to_cycle", cyc, 1 + TMO + 1);
    check("to_busy", busy, 0);
    check("to_result", result, 8'hFF);
    check("to_nloads", load_q.size(), 1);
    check("to_nodone", n_done, 0);
    step();
    check("to_once", timeout_err, 0);

    // Abort in trial 4 on the same cycle as the ready edge.
    dac_mode = 0; rdy_delay = 3; vin = 8'h3C;
    load_q.delete(); n_done = 0; start = 1'b1; cyc = 0;
    step();
    start = 1'b0;
    while (load_q.size() < 4 && cyc < 100) step();
    check("ab_trial4_cycle", cyc, 1 + 3 * (3 + SET + 2));
    repeat (3) step();
    check("ab_edge_now", dac_ready, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ab_idle", busy, 0);
    check("ab_noload", dac_load, 0);
    repeat (20) step();
    check("ab_nodone", n_done, 0);
    check("ab_result", result, 8'hFF);
    check("ab_still_idle", busy, 0);
    run_conv(8'h3C, 3, "after_abort");

    // Asynchronous reset in the middle of SETTLE.
    vin = 8'h5A; load_q.delete(); n_done = 0; start = 1'b1; cyc = 0;
    step();
    start = 1'b0;
    repeat (4) step();
    #2 reset = 1'b0;
    #1;
    check("ar_code", dac_code, 0);
    check("ar_result", result, 0);
    check("ar_busy", busy, 0);
    check("ar_load", dac_load, 0);
    check("ar_done", done, 0);
    check("ar_to", timeout_err, 0);
    repeat (2) step();
    reset = 1'b1;
    load_q.delete(); n_done = 0;
    repeat (10) step();
    check("ar_post_busy", busy, 0);
    check("ar_post_loads", load_q.size(), 0);
    check("ar_post_result", result, 0);

    // Ready edge landing in LOAD is discarded; extra start while busy is ignored.
    dac_mode = 2; dac_ready = 1'b0; vin = 8'hC3;
    repeat (2) step();
    load_q.delete(); n_done = 0; start = 1'b1; cyc = 0;
    step();
    check("le_load", dac_load, 1);
    dac_ready = 1'b1;
    repeat (2) step();
    start = 1'b0;
    repeat (6) step();
    check("le_waiting", busy, 1);
    check("le_nloads", load_q.size(), 1);
    check("le_code", dac_code, 8'h80);
    dac_ready = 1'b0;
    step();
    dac_ready = 1'b1; rdy_cd = 0; rdy_delay = 2; dac_mode = 0;
    while (n_done == 0 && cyc < 400) step();
    check("le_latency", cyc, 1 + (1 + 9 + SET + 1) + (NB - 1) * (2 + SET + 2) + 1);
    check("le_result", result, 8'hC3);
    check("le_total_loads", load_q.size(), NB);
    step();
    check("le_no_restart", busy, 0);

    // Randomized conversions against the binary-search reference.
    for (int i = 0; i < 5; i++) begin
      run_conv(NB'($urandom_range(0, 255)), int'($urandom_range(1, 5)), $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
